// File: rtl/dac_pacer_pkg.sv
// Shared definitions for the DAC sample pacer: FSM encoding, MAX5134
// command bytes, frame geometry and a saturating counter helper.
package dac_pacer_pkg;

  // Frame geometry: one command byte followed by one 16-bit sample.
  localparam int SAMPLE_W = 16;
  localparam int CMD_W    = 8;
  localparam int FRAME_W  = CMD_W + SAMPLE_W;

  // Pacer FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_ACK  = 3'd3,
    ST_DONE = 3'd4
  } pacer_state_t;

  // MAX5134 command bytes: upper nibble 0011 = write and update,
  // lower nibble is a one-hot channel select.
  localparam logic [CMD_W-1:0] CMD_NOP       = 8'b0000_0000;
  localparam logic [CMD_W-1:0] CMD_WRITE_A   = 8'b0011_0001;
  localparam logic [CMD_W-1:0] CMD_WRITE_B   = 8'b0011_0010;
  localparam logic [CMD_W-1:0] CMD_WRITE_C   = 8'b0011_0100;
  localparam logic [CMD_W-1:0] CMD_WRITE_D   = 8'b0011_1000;
  localparam logic [CMD_W-1:0] CMD_WRITE_ALL = 8'b0011_1111;

  // Increment an 8-bit counter, holding at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with combinational head read.  A pop and a
// push in the same cycle are both honoured, including when full; a push
// into an empty FIFO is never forwarded to a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);

  // The pop is evaluated first, so a full FIFO that is also popping
  // still has room for the incoming word.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_level <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces ADC samples out to the MAX5134 serialiser at a fixed rate.
// Samples are buffered in a FIFO; every SEND_INTERVAL cycles one is
// wrapped in a command byte and handed to the serialiser with a
// send/busy handshake.  Overflow, underrun and missed periods are flagged.
module dac_sample_pacer
  import dac_pacer_pkg::*;
#(
  parameter int               SEND_INTERVAL = 3624,
  parameter int               FIFO_DEPTH    = 4,
  parameter logic [CMD_W-1:0] CHANNEL_CMD   = CMD_WRITE_A
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                dac_busy,
  input  logic                clear_flags,
  output logic [FRAME_W-1:0]  dac_data,
  output logic                dac_send,
  output logic [2:0]          fifo_level,
  output logic                overflow,
  output logic [7:0]          underrun_count,
  output logic                missed_tick
);

  localparam int CNT_W = $clog2(SEND_INTERVAL);
  localparam int LVL_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  pacer_state_t        r_state;
  pacer_state_t        w_state_next;
  logic [CNT_W-1:0]    r_period_cnt;
  logic                w_tick;
  logic                r_pending;
  logic                r_missed_tick;
  logic                r_overflow;
  logic [7:0]          r_underrun_count;
  logic [SAMPLE_W-1:0] r_last_sample;
  logic [FRAME_W-1:0]  r_dac_data;
  logic                r_dac_send;
  logic                w_load;
  logic                w_pop;
  logic                w_underrun;
  logic                w_overflow_set;
  logic [SAMPLE_W-1:0] w_selected_sample;
  logic [SAMPLE_W-1:0] w_fifo_data;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [LVL_W-1:0]    w_fifo_level;

  // Sample buffer between the irregular ADC side and the paced DAC side.
  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock_in),
    .srst    (reset),
    .i_push  (sample_valid),
    .i_pop   (w_pop),
    .i_data  (sample_in),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign w_tick            = (r_period_cnt == CNT_W'(SEND_INTERVAL - 1));
  assign w_load            = (r_state == ST_LOAD);
  assign w_pop             = w_load & ~w_fifo_empty;
  assign w_underrun        = w_load & w_fifo_empty;
  assign w_overflow_set    = sample_valid & w_fifo_full & ~w_pop;
  assign w_selected_sample = w_fifo_empty ? r_last_sample : w_fifo_data;

  // Free-running period counter; one tick per SEND_INTERVAL cycles.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_period_cnt <= '0;
    end else if (w_tick) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + CNT_W'(1);
    end
  end

  // Pending request and missed-period detection.  A tick landing in
  // ST_LOAD is a fresh request, since the old one is being consumed.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_pending     <= 1'b0;
      r_missed_tick <= 1'b0;
    end else begin
      if (w_load) begin
        r_pending <= w_tick;
      end else if (w_tick) begin
        r_pending <= 1'b1;
      end
      if (w_tick && r_pending && !w_load) begin
        r_missed_tick <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: wait for a request, load a word, pulse send, then
  // follow the serialiser's busy rise and fall.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (r_pending && !dac_busy) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_SEND;
      ST_SEND: w_state_next = ST_ACK;
      ST_ACK:  if (dac_busy) w_state_next = ST_DONE;
      ST_DONE: if (!dac_busy) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Registered send strobe, high exactly for the ST_SEND cycle.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_dac_send <= 1'b0;
    end else begin
      r_dac_send <= (w_state_next == ST_SEND);
    end
  end

  // Command word and last-sample hold; an empty FIFO repeats the last value.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_dac_data    <= '0;
      r_last_sample <= '0;
    end else if (w_load) begin
      r_dac_data <= {CHANNEL_CMD, w_selected_sample};
      if (!w_fifo_empty) begin
        r_last_sample <= w_fifo_data;
      end
    end
  end

  // Status flags: a set event in the same cycle beats clear_flags.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_overflow       <= 1'b0;
      r_underrun_count <= 8'h00;
    end else begin
      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end else if (clear_flags) begin
        r_overflow <= 1'b0;
      end
      if (w_underrun) begin
        r_underrun_count <= sat_inc8(r_underrun_count);
      end else if (clear_flags) begin
        r_underrun_count <= 8'h00;
      end
    end
  end

  assign dac_data       = r_dac_data;
  assign dac_send       = r_dac_send;
  assign fifo_level     = 3'(w_fifo_level);
  assign overflow       = r_overflow;
  assign underrun_count = r_underrun_count;
  assign missed_tick    = r_missed_tick;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer with a short period and a simple
// serialiser model that answers each send with a fixed-length busy pulse.
module tb_dac_sample_pacer;

  localparam int SI          = 40;
  localparam int DEPTH       = 4;
  localparam int BUSY_CYCLES = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        dac_busy;
  logic        clear_flags;
  logic [23:0] dac_data;
  logic        dac_send;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  underrun_count;
  logic        missed_tick;
  logic        model_busy;
  logic        force_busy;

  int checks = 0;
  int errors = 0;
  int send_count = 0;

  always #5 clk = ~clk;

  assign dac_busy = model_busy | force_busy;

  dac_sample_pacer #(
    .SEND_INTERVAL (SI),
    .FIFO_DEPTH    (DEPTH),
    .CHANNEL_CMD   (8'b0011_0001)
  ) dut (
    .clock_in       (clk),
    .reset          (rst),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .dac_busy       (dac_busy),
    .clear_flags    (clear_flags),
    .dac_data       (dac_data),
    .dac_send       (dac_send),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underrun_count (underrun_count),
    .missed_tick    (missed_tick)
  );

  // Serialiser model: logs each frame, checks the send strobe is one
  // cycle wide, then raises busy for BUSY_CYCLES cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (dac_send === 1'b1) begin
        send_count++;
        $display("frame %0d: dac_data=%h t=%0t", send_count, dac_data, $time);
        @(posedge clk); #2;
        checks++;
        if (dac_send !== 1'b0) begin
          errors++;
          $display("FAIL send_width: dac_send=%b required 0", dac_send);
        end
        model_busy = 1'b1;
        repeat (BUSY_CYCLES) @(posedge clk);
        #2 model_busy = 1'b0;
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    sample_in    = d;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic wait_send(input int budget, output int n, output bit found);
    n = 0;
    while (dac_send !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    found = (dac_send === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++; if (dac_data !== 24'h0) begin errors++; $display("FAIL rst_data: got %h required %h", dac_data, 24'h0); end
    checks++; if (dac_send !== 1'b0) begin errors++; $display("FAIL rst_send: got %b required 0", dac_send); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b required 0", overflow); end
    checks++; if (underrun_count !== 8'd0) begin errors++; $display("FAIL rst_underrun: got %0d required 0", underrun_count); end
    checks++; if (missed_tick !== 1'b0) begin errors++; $display("FAIL rst_missed: got %b required 0", missed_tick); end
  endtask

  task automatic test_single_frame();
    int n; bit found; int base;
    do_reset();
    base = send_count;
    push(16'h1234);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t1_level_before: got %0d required 1", fifo_level); end
    wait_send(SI + 10, n, found);
    checks++; if (!found || n != SI + 1) begin errors++; $display("FAIL t1_latency: got %0d cycles (found=%b) required %0d", n, found, SI + 1); end
    checks++; if (dac_data !== 24'h311234) begin errors++; $display("FAIL t1_data: got %h required %h", dac_data, 24'h311234); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t1_level_after: got %0d required 0", fifo_level); end
    step(BUSY_CYCLES + 8);
    checks++; if (send_count != base + 1) begin errors++; $display("FAIL t1_send_count: got %0d required %0d", send_count - base, 1); end
  endtask

  task automatic test_underrun();
    int n; bit found;
    do_reset();
    push(16'hABCD);
    wait_send(SI + 10, n, found);
    checks++; if (!found || dac_data !== 24'h31ABCD) begin errors++; $display("FAIL t2_first: got %h (found=%b) required %h", dac_data, found, 24'h31ABCD); end
    checks++; if (underrun_count !== 8'd0) begin errors++; $display("FAIL t2_no_underrun: got %0d required 0", underrun_count); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      wait_send(2 * SI, n, found);
      checks++; if (!found || dac_data !== 24'h31ABCD) begin errors++; $display("FAIL t2_repeat%0d: got %h (found=%b) required %h", i, dac_data, found, 24'h31ABCD); end
    end
    checks++; if (underrun_count !== 8'd3) begin errors++; $display("FAIL t2_underrun: got %0d required 3", underrun_count); end
    step(1);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    checks++; if (underrun_count !== 8'd0) begin errors++; $display("FAIL t2_clear: got %0d required 0", underrun_count); end
    step(BUSY_CYCLES + 5);
  endtask

  task automatic test_overflow();
    int n; bit found; logic [15:0] exp_s;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_s = 16'(16'h1001 + i);
      push(exp_s);
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t3_level: got %0d required 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_overflow: got %b required 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      exp_s = 16'(16'h1001 + i);
      wait_send(2 * SI, n, found);
      checks++; if (!found || dac_data !== {8'h31, exp_s}) begin errors++; $display("FAIL t3_order%0d: got %h (found=%b) required %h", i, dac_data, found, {8'h31, exp_s}); end
      step(1);
    end
    wait_send(2 * SI, n, found);
    checks++; if (!found || dac_data !== 24'h311004) begin errors++; $display("FAIL t3_dropped: got %h (found=%b) required %h", dac_data, found, 24'h311004); end
    checks++; if (underrun_count !== 8'd1) begin errors++; $display("FAIL t3_underrun: got %0d required 1", underrun_count); end
    step(1);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_clear: got %b required 0", overflow); end
    step(BUSY_CYCLES + 5);
  endtask

  task automatic test_missed_tick();
    int n; bit found; int base;
    do_reset();
    force_busy = 1'b1;
    base = send_count;
    push(16'h4444);
    step(2 * SI);
    checks++; if (missed_tick !== 1'b1) begin errors++; $display("FAIL t4_missed: got %b required 1", missed_tick); end
    checks++; if (send_count != base) begin errors++; $display("FAIL t4_no_send_while_busy: got %0d sends required 0", send_count - base); end
    force_busy = 1'b0;
    wait_send(10, n, found);
    checks++; if (!found || n != 2) begin errors++; $display("FAIL t4_release: got %0d cycles (found=%b) required 2", n, found); end
    checks++; if (dac_data !== 24'h314444) begin errors++; $display("FAIL t4_data: got %h required %h", dac_data, 24'h314444); end
    step(26);
    checks++; if (send_count != base + 1) begin errors++; $display("FAIL t4_single_send: got %0d sends required 1", send_count - base); end
    checks++; if (missed_tick !== 1'b1) begin errors++; $display("FAIL t4_sticky: got %b required 1", missed_tick); end
  endtask

  task automatic test_reset_mid_frame();
    int n; bit found; logic [15:0] exp_s;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_s = 16'(16'h5001 + i);
      push(exp_s);
    end
    wait_send(SI + 10, n, found);
    checks++; if (!found || dac_data !== 24'h315001) begin errors++; $display("FAIL t5_first: got %h (found=%b) required %h", dac_data, found, 24'h315001); end
    step(5);
    checks++; if (fifo_level !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL t5_pre: level %0d overflow %b required 3 1", fifo_level, overflow); end
    rst = 1'b1;
    step(1);
    checks++; if (dac_data !== 24'h0) begin errors++; $display("FAIL t5_data: got %h required 0", dac_data); end
    checks++; if (dac_send !== 1'b0) begin errors++; $display("FAIL t5_send: got %b required 0", dac_send); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t5_level: got %0d required 0", fifo_level); end
    checks++; if (overflow !== 1'b0 || underrun_count !== 8'd0 || missed_tick !== 1'b0) begin errors++; $display("FAIL t5_flags: ovf %b und %0d miss %b required 0 0 0", overflow, underrun_count, missed_tick); end
    step(1);
    rst = 1'b0;
    wait_send(SI + 10, n, found);
    checks++; if (!found || n != SI + 2) begin errors++; $display("FAIL t5_latency: got %0d cycles (found=%b) required %0d", n, found, SI + 2); end
    checks++; if (dac_data !== 24'h310000) begin errors++; $display("FAIL t5_post_data: got %h required %h", dac_data, 24'h310000); end
    step(BUSY_CYCLES + 5);
  endtask

  task automatic test_full_push_pop();
    int n; bit found; logic [15:0] exp_s;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_s = 16'(16'h6001 + i);
      push(exp_s);
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t6_full: got %0d required 4", fifo_level); end
    step(SI - 3);
    push(16'h6005);
    checks++; if (dac_send !== 1'b1 || dac_data !== 24'h316001) begin errors++; $display("FAIL t6_align: send %b data %h required 1 %h", dac_send, dac_data, 24'h316001); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t6_level: got %0d required 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t6_overflow: got %b required 0", overflow); end
    for (int i = 1; i < 5; i++) begin
      exp_s = 16'(16'h6001 + i);
      step(1);
      wait_send(2 * SI, n, found);
      checks++; if (!found || dac_data !== {8'h31, exp_s}) begin errors++; $display("FAIL t6_order%0d: got %h (found=%b) required %h", i, dac_data, found, {8'h31, exp_s}); end
    end
    step(BUSY_CYCLES + 5);
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = 16'h0;
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    force_busy   = 1'b0;
    test_reset();
    test_single_frame();
    test_underrun();
    test_overflow();
    test_missed_tick();
    test_reset_mid_frame();
    test_full_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
